end_cycle_count: RTL and testbench

- Closing end of the approximate-region cycle measurement in the fetch/commit path.
- The fetch side captures a start cycle and pulses `begin_valid` when a buffer hit or approximate branch opens a region.
- This block runs a region FSM and detects the region end at commit. It computes elapsed cycles against the free-running cycle counter, checks them against a budget, and keeps region statistics for the performance-counter path.

---
 rtl/end_cycle_count_pkg.sv | 20 ++
 rtl/end_cycle_count_stats.sv | 29 ++
 rtl/end_cycle_count.sv | 96 +++++++++
 tb/tb_end_cycle_count.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/end_cycle_count_pkg.sv
// Shared types and constants for the approximate-region cycle measurement.
// Used by the region-end FSM and its statistics block.
package end_cycle_count_pkg;

    typedef enum logic {
        REGION_IDLE,
        REGION_ACTIVE
    } region_state_t;

    localparam int unsigned APPROX_REGION_TIMEOUT = 4096;
    localparam int unsigned APPROX_STAT_WIDTH     = 16;
    localparam int unsigned REGION_COUNTER_WIDTH  = 32;

    typedef struct packed {
        logic [REGION_COUNTER_WIDTH-1:0] elapsed;
        logic                            over_budget;
        logic                            valid;
    } region_stat_t;

endpackage

// File: rtl/end_cycle_count_stats.sv
// Region statistics: saturating count of completed regions and the
// largest elapsed value seen since reset.
module end_cycle_count_stats #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned STAT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [COUNTER_WIDTH-1:0] d,
    output logic [STAT_WIDTH-1:0]    region_count,
    output logic [COUNTER_WIDTH-1:0] max_elapsed
);

    always_ff @(posedge clk) begin
        if (rst) begin
            region_count <= '0;
            max_elapsed  <= '0;
        end else if (done) begin
            if (region_count != '1) begin
                region_count <= region_count + 1'b1;
            end
            if (d > max_elapsed) begin
                max_elapsed <= d;
            end
        end
    end

endmodule

// File: rtl/end_cycle_count.sv
// Region-end detection: tracks an open approximate region, measures its
// length at commit, flags budget overruns and abandons stale regions.
module end_cycle_count
    import end_cycle_count_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned COMMIT_WIDTH  = 2,
    parameter int unsigned TIMEOUT       = APPROX_REGION_TIMEOUT,
    parameter int unsigned STAT_WIDTH    = APPROX_STAT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     begin_valid,
    input  logic [COUNTER_WIDTH-1:0] begin_cycle,
    input  logic [COUNTER_WIDTH-1:0] cycle_counter,
    input  logic [COMMIT_WIDTH-1:0]  commit_end,
    input  logic                     flush,
    input  logic [COUNTER_WIDTH-1:0] budget,
    output logic                     region_active,
    output logic [COUNTER_WIDTH-1:0] elapsed,
    output logic                     elapsed_valid,
    output logic                     over_budget,
    output logic                     timeout,
    output logic [STAT_WIDTH-1:0]    region_count,
    output logic [COUNTER_WIDTH-1:0] max_elapsed
);

    region_state_t            state;
    logic [COUNTER_WIDTH-1:0] start;
    logic [COUNTER_WIDTH-1:0] d;
    logic                     any_end;
    logic                     timed_out;
    logic                     done;

    // Modulo subtraction makes a wrapped cycle counter measure correctly.
    assign d         = cycle_counter - start;
    assign any_end   = |commit_end;
    assign timed_out = (TIMEOUT != 0) && (d >= COUNTER_WIDTH'(TIMEOUT));
    assign done      = (state == REGION_ACTIVE) && !flush && any_end;

    assign region_active = (state == REGION_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= REGION_IDLE;
            start         <= '0;
            elapsed       <= '0;
            over_budget   <= '0;
            elapsed_valid <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            elapsed_valid <= 1'b0;
            timeout       <= 1'b0;
            case (state)
                REGION_IDLE: begin
                    if (begin_valid) begin
                        start <= begin_cycle;
                        state <= REGION_ACTIVE;
                    end
                end
                REGION_ACTIVE: begin
                    if (flush) begin
                        state <= REGION_IDLE;
                    end else if (any_end) begin
                        elapsed       <= d;
                        over_budget   <= (budget != '0) && (d > budget);
                        elapsed_valid <= 1'b1;
                        // A new begin in the end cycle opens the next region directly.
                        if (begin_valid) begin
                            start <= begin_cycle;
                        end else begin
                            state <= REGION_IDLE;
                        end
                    end else if (timed_out) begin
                        timeout <= 1'b1;
                        state   <= REGION_IDLE;
                    end
                end
                default: state <= REGION_IDLE;
            endcase
        end
    end

    end_cycle_count_stats #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .STAT_WIDTH   (STAT_WIDTH)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .d           (d),
        .region_count(region_count),
        .max_elapsed (max_elapsed)
    );

endmodule

// File: tb/tb_end_cycle_count.sv
// Directed bench for end_cycle_count with a scoreboard of expected region
// completions (TIMEOUT=16, STAT_WIDTH=2 so timeout and saturation are reachable).
module tb_end_cycle_count;

    localparam int unsigned CW  = 32;
    localparam int unsigned SW  = 2;
    localparam logic [31:0] SAT = 32'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          begin_valid;
    logic [CW-1:0] begin_cycle;
    logic [CW-1:0] cycle_counter;
    logic [1:0]    commit_end;
    logic          flush;
    logic [CW-1:0] budget;
    logic          region_active;
    logic [CW-1:0] elapsed;
    logic          elapsed_valid;
    logic          over_budget;
    logic          timeout;
    logic [SW-1:0] region_count;
    logic [CW-1:0] max_elapsed;

    end_cycle_count #(
        .COUNTER_WIDTH(CW),
        .COMMIT_WIDTH (2),
        .TIMEOUT      (16),
        .STAT_WIDTH   (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .begin_valid  (begin_valid),
        .begin_cycle  (begin_cycle),
        .cycle_counter(cycle_counter),
        .commit_end   (commit_end),
        .flush        (flush),
        .budget       (budget),
        .region_active(region_active),
        .elapsed      (elapsed),
        .elapsed_valid(elapsed_valid),
        .over_budget  (over_budget),
        .timeout      (timeout),
        .region_count (region_count),
        .max_elapsed  (max_elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] elapsed;
        logic [31:0] over;
        logic [31:0] count;
        logic [31:0] maxv;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_start  = '0;
    logic [31:0] m_count  = '0;
    logic [31:0] m_max    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_begin(input logic [31:0] cyc);
        begin_valid   = 1'b1;
        begin_cycle   = cyc;
        cycle_counter = cyc;
        tick();
        begin_valid = 1'b0;
        m_start     = cyc;
        check("begin_active", 32'(region_active), 32'd1);
    endtask

    task automatic do_end(input string tag, input logic [31:0] cyc, input logic [1:0] lanes,
                          input logic [31:0] bud, input logic bv, input logic [31:0] bcyc);
        exp_t        e;
        logic [31:0] d;
        d = cyc - m_start;
        if (m_count < SAT) m_count++;
        if (d > m_max) m_max = d;
        e.tag     = tag;
        e.elapsed = d;
        e.over    = ((bud != 0) && (d > bud)) ? 32'd1 : 32'd0;
        e.count   = m_count;
        e.maxv    = m_max;
        sb.push_back(e);

        cycle_counter = cyc;
        commit_end    = lanes;
        budget        = bud;
        begin_valid   = bv;
        begin_cycle   = bcyc;
        tick();
        commit_end  = '0;
        begin_valid = 1'b0;
        if (bv) begin
            m_start       = bcyc;
            cycle_counter = bcyc;
        end

        check({tag, "_valid"}, 32'(elapsed_valid), 32'd1);
        if (elapsed_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_elapsed"}, elapsed, e.elapsed);
            check({e.tag, "_over"}, 32'(over_budget), e.over);
            check({e.tag, "_count"}, 32'(region_count), e.count);
            check({e.tag, "_max"}, max_elapsed, e.maxv);
        end
        check({tag, "_active"}, 32'(region_active), bv ? 32'd1 : 32'd0);
        tick();
        check({tag, "_pulse_end"}, 32'(elapsed_valid), 32'd0);
        check({tag, "_hold"}, elapsed, d);
    endtask

    initial begin
        logic [31:0] seen_at;
        rst           = 1'b1;
        begin_valid   = 1'b0;
        begin_cycle   = '0;
        cycle_counter = '0;
        commit_end    = '0;
        flush         = 1'b0;
        budget        = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_active", 32'(region_active), 32'd0);
        check("rst_elapsed", elapsed, 32'd0);
        check("rst_valid", 32'(elapsed_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_count", 32'(region_count), 32'd0);
        check("rst_max", max_elapsed, 32'd0);

        // commit_end in IDLE does nothing
        commit_end    = 2'b01;
        cycle_counter = 32'd50;
        tick();
        commit_end = '0;
        check("idle_end_valid", 32'(elapsed_valid), 32'd0);
        check("idle_end_active", 32'(region_active), 32'd0);

        do_begin(32'd100);
        do_end("basic", 32'd130, 2'b01, 32'd0, 1'b0, 32'd0);

        do_begin(32'hFFFF_FFF0);
        do_end("wrap", 32'h0000_0010, 2'b10, 32'd0, 1'b0, 32'd0);

        do_begin(32'd5);
        do_end("budget20", 32'd40, 2'b01, 32'd20, 1'b0, 32'd0);
        do_begin(32'd5);
        do_end("budget0", 32'd40, 2'b11, 32'd0, 1'b0, 32'd0);

        // flush beats a same-cycle end and begin
        do_begin(32'd200);
        cycle_counter = 32'd210;
        flush         = 1'b1;
        commit_end    = 2'b11;
        begin_valid   = 1'b1;
        begin_cycle   = 32'd210;
        tick();
        flush       = 1'b0;
        commit_end  = '0;
        begin_valid = 1'b0;
        check("flush_valid", 32'(elapsed_valid), 32'd0);
        check("flush_timeout", 32'(timeout), 32'd0);
        check("flush_active", 32'(region_active), 32'd0);
        check("flush_count", 32'(region_count), m_count);

        // timeout: pulse must follow the edge where the counter reads 316
        do_begin(32'd300);
        seen_at = '0;
        for (int i = 1; i <= 64; i++) begin
            cycle_counter = 32'd300 + 32'(i);
            tick();
            if (timeout) begin
                seen_at = cycle_counter;
                break;
            end
        end
        check("timeout_at", seen_at, 32'd316);
        check("timeout_active", 32'(region_active), 32'd0);
        tick();
        check("timeout_pulse_end", 32'(timeout), 32'd0);
        cycle_counter = 32'd320;
        commit_end    = 2'b01;
        tick();
        commit_end = '0;
        check("late_end_valid", 32'(elapsed_valid), 32'd0);
        check("late_end_count", 32'(region_count), m_count);

        // back-to-back regions, nested begin ignored, count saturates
        do_begin(32'd490);
        do_end("b2b_first", 32'd500, 2'b01, 32'd0, 1'b1, 32'd500);
        cycle_counter = 32'd505;
        begin_valid   = 1'b1;
        begin_cycle   = 32'd505;
        tick();
        begin_valid = 1'b0;
        check("nest_active", 32'(region_active), 32'd1);
        do_end("b2b_second", 32'd510, 2'b10, 32'd0, 1'b0, 32'd0);

        // reset mid-region discards everything without pulses
        do_begin(32'd600);
        rst           = 1'b1;
        cycle_counter = 32'd605;
        commit_end    = 2'b01;
        tick();
        rst        = 1'b0;
        commit_end = '0;
        check("mid_rst_valid", 32'(elapsed_valid), 32'd0);
        check("mid_rst_active", 32'(region_active), 32'd0);
        check("mid_rst_count", 32'(region_count), 32'd0);
        check("mid_rst_max", max_elapsed, 32'd0);
        check("mid_rst_elapsed", elapsed, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
